// File: rtl/irq_arbiter_pkg.sv
// Shared types and register map for the interrupt arbiter.
// FSM states, cfg register addresses, CTRL bit positions and the vector helper.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_EOI_BIT = 1;

    localparam int ID_W = 4;

    // Handler address; arithmetic is deliberately 16-bit so it wraps mod 2^16.
    function automatic logic [15:0] vector_of(input logic [15:0]     base,
                                              input logic [15:0]     stride,
                                              input logic [ID_W-1:0] id);
        return base + (16'(id) * stride);
    endfunction

endpackage

// File: rtl/irq_arbiter_priority_encoder.sv
// Combinational lowest-set-index finder; index 0 has the highest priority.
// Zero latency, no flow control.
module irq_priority_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         any_o,
    output logic [3:0]   idx_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        any_o = 1'b0;
        idx_o = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_o = 1'b1;
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending, mask/enable, fixed-priority grant to one CPU irq line.
// Grant one cycle after an eligible pending bit; one request in flight at a time (no nesting).
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int          NUM_SRC       = 8,
    parameter logic [15:0] VECTOR_BASE   = 16'h0100,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0010
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] src_irq_i,
    output logic               irq_o,
    output logic [15:0]        irq_vector_o,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [15:0]        cfg_wdata_i,
    output logic [15:0]        cfg_rdata_o
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               en_q, en_d;
    irq_state_t         state_q, state_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic               irq_q, irq_d;
    logic [15:0]        vector_q, vector_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] active_onehot;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] sw_clr;
    logic               active_enabled;
    logic               enc_any;
    logic [ID_W-1:0]    enc_idx;
    logic               wr_mask, wr_pend, wr_ctrl, sw_eoi;

    assign rise     = src_irq_i & ~src_q;
    assign eligible = pending_q & mask_q & {NUM_SRC{en_q}};

    assign wr_mask = cfg_we_i && (cfg_addr_i == ADDR_MASK);
    assign wr_pend = cfg_we_i && (cfg_addr_i == ADDR_PENDING);
    assign wr_ctrl = cfg_we_i && (cfg_addr_i == ADDR_CTRL);
    assign sw_eoi  = wr_ctrl && cfg_wdata_i[CTRL_EOI_BIT];

    irq_priority_encoder #(
        .N (NUM_SRC)
    ) u_prio (
        .req_i (eligible),
        .any_o (enc_any),
        .idx_o (enc_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            active_onehot[i] = (active_id_q == 4'(i));
        end
    end

    // The grant is withdrawn only for the granted source losing its mask or the global enable.
    assign active_enabled = en_q && |(mask_q & active_onehot);

    always_comb begin
        state_d     = state_q;
        irq_d       = irq_q;
        active_id_d = active_id_q;
        vector_d    = vector_q;
        ack_clr     = '0;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    active_id_d = enc_idx;
                    vector_d    = vector_of(VECTOR_BASE, VECTOR_STRIDE, enc_idx);
                    irq_d       = 1'b1;
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                if (irq_ack_i) begin
                    ack_clr = active_onehot;
                    irq_d   = 1'b0;
                    state_d = SERVICE;
                end else if (!active_enabled) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                irq_d = 1'b0;
                if (irq_eoi_i || sw_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // A fresh edge always beats a clear from ack or software in the same cycle.
    always_comb begin
        sw_clr    = wr_pend ? cfg_wdata_i[NUM_SRC-1:0] : '0;
        pending_d = (pending_q & ~(sw_clr | ack_clr)) | rise;
        mask_d    = wr_mask ? cfg_wdata_i[NUM_SRC-1:0] : mask_q;
        en_d      = wr_ctrl ? cfg_wdata_i[CTRL_EN_BIT] : en_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            src_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            en_q        <= 1'b0;
            state_q     <= IDLE;
            active_id_q <= '0;
            irq_q       <= 1'b0;
            vector_q    <= '0;
        end else begin
            src_q       <= src_irq_i;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            en_q        <= en_d;
            state_q     <= state_d;
            active_id_q <= active_id_d;
            irq_q       <= irq_d;
            vector_q    <= vector_d;
        end
    end

    assign irq_o        = irq_q;
    assign irq_vector_o = vector_q;

    logic [15:0] mask_ext, pend_ext, ctrl_ext, status_ext;

    always_comb begin
        mask_ext                = '0;
        mask_ext[NUM_SRC-1:0]   = mask_q;
        pend_ext                = '0;
        pend_ext[NUM_SRC-1:0]   = pending_q;
        ctrl_ext                = '0;
        ctrl_ext[CTRL_EN_BIT]   = en_q;
        status_ext              = {8'h00, state_q, 2'b00, active_id_q};
    end

    always_comb begin
        case (cfg_addr_i)
            ADDR_MASK:    cfg_rdata_o = mask_ext;
            ADDR_PENDING: cfg_rdata_o = pend_ext;
            ADDR_CTRL:    cfg_rdata_o = ctrl_ext;
            default:      cfg_rdata_o = status_ext;
        endcase
    end

endmodule
